instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 73 +++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven instruction fetch with 2-entry {instr, pc} buffer and branch redirect
module instr_fetch #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [INSTR_W-1:0] instr,
   output logic [1:0]         opcode,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready
);
   logic [PC_W-1:0]    pc, inflight_pc;
   logic [PC_W-1:0]    pc_q [2];
   logic [INSTR_W-1:0] ins_q [2];
   logic               run, inflight, squash, pop, push;
   logic [1:0]         count, cnt_pop;
   assign instr_valid = count != 2'd0;
   assign instr       = ins_q[0];
   assign instr_pc    = pc_q[0];
   assign opcode      = ins_q[0][INSTR_W-1 -: 2];
   assign imem_addr   = pc;
   assign pop         = instr_valid & instr_ready;
   assign cnt_pop     = count - {1'b0, pop};
   // a response arriving in the redirect cycle is stale and never enters the buffer
   assign push        = inflight & ~squash & ~branch_taken;
   assign imem_req    = run & enable & ~branch_taken & (({1'b0, cnt_pop} + {2'b0, inflight}) < 3'd2);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= '0;
         inflight_pc <= '0;
         run         <= 1'b0;
         inflight    <= 1'b0;
         squash      <= 1'b0;
         count       <= 2'd0;
         pc_q[0]     <= '0;
         pc_q[1]     <= '0;
         ins_q[0]    <= '0;
         ins_q[1]    <= '0;
      end else begin
         run      <= 1'b1;
         inflight <= imem_req;
         squash   <= branch_taken & inflight;
         if (imem_req) begin
            inflight_pc <= pc;
            pc          <= pc + PC_W'(1);
         end
         if (branch_taken) begin
            pc    <= branch_target;
            count <= 2'd0;
         end else begin
            if (pop) begin
               ins_q[0] <= ins_q[1];
               pc_q[0]  <= pc_q[1];
            end
            // tail slot is computed after the pop so push+pop keeps order
            if (push) begin
               ins_q[cnt_pop[0]] <= imem_rdata;
               pc_q[cnt_pop[0]]  <= inflight_pc;
            end
            count <= cnt_pop + {1'b0, push};
         end
      end
   end
   always_ff @(posedge clk) if (rst_n) assert (!(push && cnt_pop == 2'd2));
endmodule
